// File: rtl/sd_clk_gen.sv
// sd_clk_gen: SD card clock generator with a programmable divisor.
//
// The output runs at clk / (2 * (active_div + 1)) with a 50% duty cycle.
// A new divisor waits in a pending register and takes effect only at a
// period boundary, which is the end of the low phase, or while idle.
// Because of this, a phase that has already started keeps its length.
// When enable drops, the current period still finishes before the clock
// parks low, so no runt pulse is produced.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   div          requested divisor (half-period = div + 1 clk cycles)
//   div_load     single-cycle strobe that captures div into the pending slot
//   enable       level; 1 = run sd_clk, 0 = stop after the current period
//   sd_clk       generated SD clock (registered)
//   sd_clk_rise  one-cycle pulse in the first cycle sd_clk is high
//   sd_clk_fall  one-cycle pulse in the first cycle sd_clk is low after high
//   active_div   divisor currently in use
//   stable       running, with no divisor change pending
module sd_clk_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 62
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 div_load,
  input  logic                 enable,
  output logic                 sd_clk,
  output logic                 sd_clk_rise,
  output logic                 sd_clk_fall,
  output logic [DIV_WIDTH-1:0] active_div,
  output logic                 stable
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] active_div_nxt;
  logic [DIV_WIDTH-1:0] pending_div, pending_div_nxt;
  logic                 pending, pending_nxt;
  logic                 sd_clk_nxt, rise_nxt, fall_nxt, stable_nxt;
  logic                 apply;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      active_div  <= DIV_WIDTH'(DEFAULT_DIV);
      pending_div <= '0;
      pending     <= 1'b0;
      sd_clk      <= 1'b0;
      sd_clk_rise <= 1'b0;
      sd_clk_fall <= 1'b0;
      stable      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      active_div  <= active_div_nxt;
      pending_div <= pending_div_nxt;
      pending     <= pending_nxt;
      sd_clk      <= sd_clk_nxt;
      sd_clk_rise <= rise_nxt;
      sd_clk_fall <= fall_nxt;
      stable      <= stable_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sd_clk_nxt = sd_clk;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    apply      = 1'b0;

    unique case (state)
      IDLE: begin
        sd_clk_nxt = 1'b0;
        cnt_nxt    = '0;
        apply      = pending;
        if (enable) begin
          state_nxt  = HIGH;
          sd_clk_nxt = 1'b1;
          rise_nxt   = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == active_div) begin
          state_nxt  = LOW;
          sd_clk_nxt = 1'b0;
          fall_nxt   = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOW: begin
        if (cnt == active_div) begin
          // Period boundary: the only place a running clock picks up a new divisor
          apply   = pending;
          cnt_nxt = '0;
          if (enable) begin
            state_nxt  = HIGH;
            sd_clk_nxt = 1'b1;
            rise_nxt   = 1'b1;
          end else begin
            state_nxt  = IDLE;
            sd_clk_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        sd_clk_nxt = 1'b0;
        cnt_nxt    = '0;
      end
    endcase

    active_div_nxt = apply ? pending_div : active_div;

    // A load that coincides with an apply becomes the next pending value.
    // The apply still uses the value that was already pending.
    pending_nxt     = div_load ? 1'b1 : (apply ? 1'b0 : pending);
    pending_div_nxt = div_load ? div : pending_div;

    stable_nxt = (state_nxt != IDLE) && !pending_nxt;
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed testbench for sd_clk_gen. Inputs are driven and outputs are
// sampled on the falling edge of clk.
module tb_sd_clk_gen;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] div;
  logic          div_load;
  logic          enable;
  logic          sd_clk;
  logic          sd_clk_rise;
  logic          sd_clk_fall;
  logic [DW-1:0] active_div;
  logic          stable;

  int vec = 0;
  int errs = 0;

  sd_clk_gen #(.DIV_WIDTH(DW), .DEFAULT_DIV(62)) dut (
    .clk        (clk),
    .reset      (reset),
    .div        (div),
    .div_load   (div_load),
    .enable     (enable),
    .sd_clk     (sd_clk),
    .sd_clk_rise(sd_clk_rise),
    .sd_clk_fall(sd_clk_fall),
    .active_div (active_div),
    .stable     (stable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    enable   = 1'b0;
    div_load = 1'b0;
    div      = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset;
    int bad;
    int n;
    do_reset();
    vec++; if (sd_clk !== 1'b0) begin errs++; $display("FAIL reset_sd_clk: got %b want 0", sd_clk); end
    vec++; if (active_div !== 16'd62) begin errs++; $display("FAIL reset_active_div: got %0d want 62", active_div); end
    vec++; if (stable !== 1'b0) begin errs++; $display("FAIL reset_stable: got %b want 0", stable); end
    vec++; if (sd_clk_rise !== 1'b0 || sd_clk_fall !== 1'b0) begin errs++; $display("FAIL reset_strobes: rise %b fall %b want 0 0", sd_clk_rise, sd_clk_fall); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (sd_clk !== 1'b0 || sd_clk_rise !== 1'b0 || sd_clk_fall !== 1'b0 || stable !== 1'b0) bad++;
      step();
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL idle_quiet: %0d bad cycles want 0", bad); end
    enable = 1'b1;
    step();
    vec++; if (sd_clk !== 1'b1 || sd_clk_rise !== 1'b1) begin errs++; $display("FAIL start_rise: sd_clk %b rise %b want 1 1", sd_clk, sd_clk_rise); end
    vec++; if (stable !== 1'b1) begin errs++; $display("FAIL start_stable: got %b want 1", stable); end
    n = 0;
    while (sd_clk === 1'b1 && n < 1000) begin n++; step(); end
    vec++; if (n != 63) begin errs++; $display("FAIL default_high_len: got %0d want 63", n); end
    n = 0;
    while (sd_clk === 1'b0 && n < 1000) begin n++; step(); end
    vec++; if (n != 63) begin errs++; $display("FAIL default_low_len: got %0d want 63", n); end
    vec++; if (sd_clk_rise !== 1'b1) begin errs++; $display("FAIL default_second_rise: got %b want 1", sd_clk_rise); end
  endtask

  task automatic test_div0;
    int bad;
    logic prev;
    do_reset();
    div      = 16'd0;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    vec++; if (active_div !== 16'd62 || stable !== 1'b0) begin errs++; $display("FAIL div0_pending: active %0d stable %b want 62 0", active_div, stable); end
    enable = 1'b1;
    step();
    vec++; if (active_div !== 16'd0) begin errs++; $display("FAIL div0_active: got %0d want 0", active_div); end
    vec++; if (sd_clk !== 1'b1 || sd_clk_rise !== 1'b1 || stable !== 1'b1) begin errs++; $display("FAIL div0_start: sd_clk %b rise %b stable %b want 1 1 1", sd_clk, sd_clk_rise, stable); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      prev = sd_clk;
      step();
      if (sd_clk !== ~prev || sd_clk_rise !== sd_clk || sd_clk_fall !== ~sd_clk) bad++;
      if (sd_clk_rise === 1'b1 && sd_clk_fall === 1'b1) bad++;
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL div0_toggle: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_div_change;
    int n;
    do_reset();
    div      = 16'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
    step();
    vec++; if (active_div !== 16'd3 || sd_clk_rise !== 1'b1) begin errs++; $display("FAIL chg_start: active %0d rise %b want 3 1", active_div, sd_clk_rise); end
    step();
    div      = 16'd1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    vec++; if (stable !== 1'b0 || active_div !== 16'd3) begin errs++; $display("FAIL chg_pending: stable %b active %0d want 0 3", stable, active_div); end
    n = 2;
    while (sd_clk === 1'b1 && n < 1000) begin n++; step(); end
    vec++; if (n != 4) begin errs++; $display("FAIL chg_high_len: got %0d want 4", n); end
    vec++; if (stable !== 1'b0 || sd_clk_fall !== 1'b1) begin errs++; $display("FAIL chg_low_start: stable %b fall %b want 0 1", stable, sd_clk_fall); end
    n = 0;
    while (sd_clk === 1'b0 && n < 1000) begin n++; step(); end
    vec++; if (n != 4) begin errs++; $display("FAIL chg_low_len: got %0d want 4", n); end
    vec++; if (active_div !== 16'd1 || stable !== 1'b1 || sd_clk_rise !== 1'b1) begin errs++; $display("FAIL chg_applied: active %0d stable %b rise %b want 1 1 1", active_div, stable, sd_clk_rise); end
    n = 0;
    while (sd_clk === 1'b1 && n < 1000) begin n++; step(); end
    vec++; if (n != 2) begin errs++; $display("FAIL chg_new_high: got %0d want 2", n); end
    n = 0;
    while (sd_clk === 1'b0 && n < 1000) begin n++; step(); end
    vec++; if (n != 2) begin errs++; $display("FAIL chg_new_low: got %0d want 2", n); end
  endtask

  task automatic test_enable_stop;
    int nhi, nstab, nfall, nrise;
    do_reset();
    div      = 16'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
    step();
    step();
    enable = 1'b0;
    nhi = 0; nstab = 0; nfall = 0; nrise = 0;
    for (int i = 0; i < 20; i++) begin
      if (sd_clk === 1'b1) nhi++;
      if (stable === 1'b1) nstab++;
      if (sd_clk_fall === 1'b1) nfall++;
      if (sd_clk_rise === 1'b1) nrise++;
      step();
    end
    vec++; if (nhi != 3) begin errs++; $display("FAIL stop_high_rest: got %0d want 3", nhi); end
    vec++; if (nstab != 7) begin errs++; $display("FAIL stop_running_cycles: got %0d want 7", nstab); end
    vec++; if (nfall != 1 || nrise != 0) begin errs++; $display("FAIL stop_strobes: fall %0d rise %0d want 1 0", nfall, nrise); end
    vec++; if (sd_clk !== 1'b0) begin errs++; $display("FAIL stop_parked: got %b want 0", sd_clk); end
    enable = 1'b1;
    step();
    vec++; if (sd_clk !== 1'b1 || sd_clk_rise !== 1'b1) begin errs++; $display("FAIL restart: sd_clk %b rise %b want 1 1", sd_clk, sd_clk_rise); end
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset();
    div      = 16'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
    step();
    div      = 16'd5;
    div_load = 1'b1;
    step();
    div = 16'd2;
    step();
    div_load = 1'b0;
    n = 0;
    while (sd_clk_rise !== 1'b1 && n < 100) begin n++; step(); end
    vec++; if (n != 6) begin errs++; $display("FAIL b2b_boundary_wait: got %0d want 6", n); end
    vec++; if (active_div !== 16'd2 || stable !== 1'b1) begin errs++; $display("FAIL b2b_last_wins: active %0d stable %b want 2 1", active_div, stable); end
    for (int i = 0; i < 5; i++) step();
    vec++; if (sd_clk !== 1'b0) begin errs++; $display("FAIL b2b_boundary_cycle: sd_clk %b want 0", sd_clk); end
    div      = 16'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    vec++; if (sd_clk_rise !== 1'b1 || active_div !== 16'd2 || stable !== 1'b0) begin errs++; $display("FAIL b2b_load_on_boundary: rise %b active %0d stable %b want 1 2 0", sd_clk_rise, active_div, stable); end
    n = 1;
    step();
    while (sd_clk_rise !== 1'b1 && n < 100) begin n++; step(); end
    vec++; if (n != 6) begin errs++; $display("FAIL b2b_period: got %0d want 6", n); end
    vec++; if (active_div !== 16'd7 || stable !== 1'b1) begin errs++; $display("FAIL b2b_deferred: active %0d stable %b want 7 1", active_div, stable); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    div      = 16'd10;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
    step();
    step();
    step();
    div      = 16'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    vec++; if (sd_clk !== 1'b1 || active_div !== 16'd10 || stable !== 1'b0) begin errs++; $display("FAIL rmid_pre: sd_clk %b active %0d stable %b want 1 10 0", sd_clk, active_div, stable); end
    reset = 1'b1;
    step();
    vec++; if (sd_clk !== 1'b0 || sd_clk_fall !== 1'b0 || sd_clk_rise !== 1'b0) begin errs++; $display("FAIL rmid_clk: sd_clk %b fall %b rise %b want 0 0 0", sd_clk, sd_clk_fall, sd_clk_rise); end
    vec++; if (active_div !== 16'd62 || stable !== 1'b0) begin errs++; $display("FAIL rmid_state: active %0d stable %b want 62 0", active_div, stable); end
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vec++; if (active_div !== 16'd62 || sd_clk !== 1'b0) begin errs++; $display("FAIL rmid_pending_cleared: active %0d sd_clk %b want 62 0", active_div, sd_clk); end
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    div      = '0;
    div_load = 1'b0;
    test_reset();
    test_div0();
    test_div_change();
    test_enable_stop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
